// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned BLOCK_W         = 512;
  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam logic [7:0]  PAD_BYTE        = 8'h80;
  localparam int unsigned LEN_FIELD_WORDS = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StHold,
    StDone
  } pad_state_e;

  // Blocks needed for a message of len bytes: data + 0x80 + 8-byte length field.
  function automatic logic [31:0] calc_num_blocks(input logic [63:0] len);
    logic [63:0] n;
    n = ((len + 64'd8) >> 6) + 64'd1;
    return n[31:0];
  endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 word-addressed block buffer with synchronous clear and a flattened
// 512-bit read port (word0 in the most significant bits).
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic               iClk,
  input  logic               iClear,
  input  logic               iWrEn,
  input  logic [3:0]         iWrAddr,
  input  logic [31:0]        iWrData,
  output logic [BLOCK_W-1:0] oBlock
);

  logic [31:0] mem_q [WORDS_PER_BLOCK];

  always_ff @(posedge iClk) begin
    if (iClear) begin
      for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
        mem_q[i] <= '0;
      end
    end else if (iWrEn) begin
      mem_q[iWrAddr] <= iWrData;
    end
  end

  always_comb begin
    oBlock = '0;
    for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
      oBlock[BLOCK_W-1-32*i -: 32] = mem_q[i];
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder feeding 512-bit blocks to the SHA-256 core.
// Define SHA256_PAD_DBUF_EN for a ping-pong buffer that fills during HOLD.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic               iStart,
  input  logic [LEN_W-1:0]   iMsgLen,
  input  logic [31:0]        iWord,
  input  logic               iWordValid,
  output logic               oWordReady,
  output logic [BLOCK_W-1:0] oMessage,
  output logic               oDataValid,
  input  logic               iReadBlock,
  output logic [31:0]        oNumberBlock,
  output logic               oBusy
);

  pad_state_e       state_q;
  logic [4:0]       wi_q;
  logic [LEN_W-1:0] len_q, rem_q, rem_next;
  logic             term_q, lenw_q, valid_q, busy_q;
  logic [31:0]      num_blocks_q;
  logic             soft_clr, accept, last_word;
  logic             wr_en, wr_term, wr_lenw;
  logic [31:0]      wr_data, len_hi, len_lo;

`ifdef SHA256_PAD_DBUF_EN
  logic             wr_sel_q, front_q, back_full_q;
`endif

  assign soft_clr  = iReset | ~iEnable;
  assign accept    = (state_q == StFill) && (rem_q != '0) && iWordValid;
  assign last_word = (wi_q == 5'd15);
  assign rem_next  = (rem_q[LEN_W-1:2] != '0) ? rem_q - LEN_W'(4) : '0;
  assign len_hi    = 32'(len_q >> (LEN_W - 3));
  assign len_lo    = 32'({len_q, 3'b000});

  // Word written into the block this cycle, from the stream or from padding.
  always_comb begin
    wr_en   = 1'b0;
    wr_term = 1'b0;
    wr_lenw = 1'b0;
    wr_data = '0;
    if (accept) begin
      wr_en = 1'b1;
      if (rem_q[LEN_W-1:2] != '0) begin
        wr_data = iWord;
      end else begin
        wr_term = 1'b1;
        case (rem_q[1:0])
          2'd1:    wr_data = {iWord[31:24], PAD_BYTE, 16'h0000};
          2'd2:    wr_data = {iWord[31:16], PAD_BYTE, 8'h00};
          default: wr_data = {iWord[31:8], PAD_BYTE};
        endcase
      end
    end else if (state_q == StPad) begin
      wr_en = 1'b1;
      if (!term_q) begin
        wr_data = {PAD_BYTE, 24'h000000};
        wr_term = 1'b1;
      end else if (wi_q == 5'd14) begin
        wr_data = len_hi;
        wr_lenw = 1'b1;
      end else if (last_word && lenw_q) begin
        wr_data = len_lo;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (soft_clr) begin
      state_q      <= StIdle;
      wi_q         <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      term_q       <= 1'b0;
      lenw_q       <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      num_blocks_q <= '0;
`ifdef SHA256_PAD_DBUF_EN
      wr_sel_q     <= 1'b1;
      front_q      <= 1'b0;
      back_full_q  <= 1'b0;
`endif
    end else begin
`ifdef SHA256_PAD_DBUF_EN
      if (valid_q && iReadBlock) valid_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            len_q        <= iMsgLen;
            rem_q        <= iMsgLen;
            num_blocks_q <= calc_num_blocks(64'(iMsgLen));
            wi_q         <= '0;
            term_q       <= 1'b0;
            lenw_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= (iMsgLen == '0) ? StPad : StFill;
          end
        end
        StFill, StPad: begin
          if (wr_en) begin
            wi_q <= wi_q + 5'd1;
            if (wr_term) term_q <= 1'b1;
            if (wr_lenw) lenw_q <= 1'b1;
            if (accept) rem_q <= rem_next;
            if (last_word) begin
`ifdef SHA256_PAD_DBUF_EN
              // Front free (or being read now): completed block swaps in at once.
              if (!valid_q || iReadBlock) begin
                front_q  <= wr_sel_q;
                wr_sel_q <= ~wr_sel_q;
                valid_q  <= 1'b1;
                wi_q     <= '0;
                if (lenw_q) state_q <= StHold;
                else if (accept ? (rem_next != '0) : (rem_q != '0)) state_q <= StFill;
                else state_q <= StPad;
              end else begin
                state_q     <= StHold;
                back_full_q <= 1'b1;
              end
`else
              state_q <= StHold;
              valid_q <= 1'b1;
`endif
            end else if (accept && (rem_next == '0)) begin
              state_q <= StPad;
            end
          end
        end
        StHold: begin
          if (iReadBlock) begin
            wi_q <= '0;
`ifdef SHA256_PAD_DBUF_EN
            if (back_full_q) begin
              front_q     <= wr_sel_q;
              wr_sel_q    <= ~wr_sel_q;
              valid_q     <= 1'b1;
              back_full_q <= 1'b0;
              if (lenw_q) state_q <= StHold;
              else state_q <= (rem_q != '0) ? StFill : StPad;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
            end
`else
            valid_q <= 1'b0;
            if (lenw_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
            end else begin
              state_q <= (rem_q != '0) ? StFill : StPad;
            end
`endif
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oWordReady   = (state_q == StFill) && (rem_q != '0);
  assign oDataValid   = valid_q;
  assign oBusy        = busy_q;
  assign oNumberBlock = num_blocks_q;

`ifdef SHA256_PAD_DBUF_EN
  logic [BLOCK_W-1:0] blk0, blk1;

  sha256_block_buf u_buf0 (
    .iClk    (iClk),
    .iClear  (soft_clr | (valid_q & iReadBlock & ~front_q)),
    .iWrEn   (wr_en & ~wr_sel_q),
    .iWrAddr (wi_q[3:0]),
    .iWrData (wr_data),
    .oBlock  (blk0)
  );

  sha256_block_buf u_buf1 (
    .iClk    (iClk),
    .iClear  (soft_clr | (valid_q & iReadBlock & front_q)),
    .iWrEn   (wr_en & wr_sel_q),
    .iWrAddr (wi_q[3:0]),
    .iWrData (wr_data),
    .oBlock  (blk1)
  );

  assign oMessage = front_q ? blk1 : blk0;
`else
  sha256_block_buf u_buf (
    .iClk    (iClk),
    .iClear  (soft_clr | ((state_q == StHold) & iReadBlock)),
    .iWrEn   (wr_en),
    .iWrAddr (wi_q[3:0]),
    .iWrData (wr_data),
    .oBlock  (oMessage)
  );
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: byte-level padding model plus
// directed messages covering the length boundaries, stalls and clears.
module tb_sha256_msg_padder;

  logic         iClk;
  logic         iReset;
  logic         iEnable;
  logic         iStart;
  logic [31:0]  iMsgLen;
  logic [31:0]  iWord;
  logic         iWordValid;
  logic         oWordReady;
  logic [511:0] oMessage;
  logic         oDataValid;
  logic         iReadBlock;
  logic [31:0]  oNumberBlock;
  logic         oBusy;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iEnable      (iEnable),
    .iStart       (iStart),
    .iMsgLen      (iMsgLen),
    .iWord        (iWord),
    .iWordValid   (iWordValid),
    .oWordReady   (oWordReady),
    .oMessage     (oMessage),
    .oDataValid   (oDataValid),
    .iReadBlock   (iReadBlock),
    .oNumberBlock (oNumberBlock),
    .oBusy        (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int           n_checks;
  int           n_fail;
  bit           chk_en;
  int           exp_idx;
  int           exp_nblk;
  logic [511:0] exp_blocks [8];
  byte unsigned msg_q [$];
  byte unsigned junk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic make_msg(input int len, input int seed, input int step);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'(seed + i * step));
  endtask

  // Big-endian word i of the message; bytes past the end carry junk.
  function automatic logic [31:0] word_at(input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[31-8*k -: 8] = (4 * i + k < msg_q.size()) ? msg_q[4*i+k] : junk;
    end
    return w;
  endfunction

  // Padded byte stream: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_model(input int len);
    byte unsigned p [$];
    logic [63:0]  bitlen;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bitlen = 64'(len) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    exp_nblk = p.size() / 64;
    for (int b = 0; b < exp_nblk; b++) begin
      for (int j = 0; j < 64; j++) exp_blocks[b][511-8*j -: 8] = p[b*64+j];
    end
    exp_idx = 0;
  endtask

  always @(negedge iClk) begin
    if (chk_en && oDataValid) begin
      check("block_index_in_range", 512'(exp_idx < exp_nblk), 512'd1);
      if (exp_idx < exp_nblk) check("block_data", oMessage, exp_blocks[exp_idx]);
      check("ready_low_in_hold", oWordReady, 1'b0);
      check("busy_in_hold", oBusy, 1'b1);
      check("nblk_in_hold", oNumberBlock, 32'(exp_nblk));
    end
  end

  task automatic run_msg(input string name, input int len, input int hold_cycles,
                         input bit keep_valid, input int nb_lit);
    int nwords, widx, cyc, hold, reads;
    bit acc, rd;
    build_model(len);
    nwords = (len + 3) / 4;
    @(negedge iClk);
    iStart  = 1'b1;
    iMsgLen = 32'(len);
    @(negedge iClk);
    iStart = 1'b0;
    check({name, "/nblk"}, oNumberBlock, 32'(nb_lit));
    check({name, "/busy"}, oBusy, 1'b1);
    chk_en = 1'b1;
    widx = 0; cyc = 0; hold = 0; reads = 0;
    while (reads < exp_nblk && cyc < 3000) begin
      iWordValid = (widx < nwords) || keep_valid;
      iWord      = (widx < nwords) ? word_at(widx) : 32'hDEADBEEF;
      iStart     = keep_valid && oDataValid;
      if (iStart) iMsgLen = 32'd5;
      iReadBlock = 1'b0;
      if (oDataValid) begin
        if (hold >= hold_cycles) begin
          iReadBlock = 1'b1;
          hold = 0;
        end else begin
          hold++;
        end
      end
      acc = oWordReady && iWordValid && (widx < nwords);
      rd  = iReadBlock;
      @(posedge iClk);
      if (acc) widx++;
      if (rd) begin
        reads++;
        exp_idx++;
      end
      cyc++;
      @(negedge iClk);
    end
    iWordValid = 1'b0;
    iStart     = 1'b0;
    iReadBlock = 1'b0;
    check({name, "/all_blocks_read"}, 32'(reads), 32'(exp_nblk));
    check({name, "/words_consumed"}, 32'(widx), 32'(nwords));
    check({name, "/busy_after"}, oBusy, 1'b0);
    check({name, "/valid_after"}, oDataValid, 1'b0);
    check({name, "/msg_cleared"}, oMessage, 512'd0);
    check({name, "/nblk_held"}, oNumberBlock, 32'(nb_lit));
    chk_en = 1'b0;
    repeat (2) @(negedge iClk);
  endtask

  task automatic check_cleared(input string name);
    check({name, "/msg"}, oMessage, 512'd0);
    check({name, "/valid"}, oDataValid, 1'b0);
    check({name, "/ready"}, oWordReady, 1'b0);
    check({name, "/nblk"}, oNumberBlock, 32'd0);
    check({name, "/busy"}, oBusy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0; exp_idx = 0; exp_nblk = 0; junk = 8'hA5;
    iReset = 1'b1; iEnable = 1'b1; iStart = 1'b0; iMsgLen = '0;
    iWord = '0; iWordValid = 1'b0; iReadBlock = 1'b0;
    repeat (3) @(negedge iClk);
    check_cleared("reset");
    iReset = 1'b0;
    @(negedge iClk);

    // "abc"
    junk = 8'h00;
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    check("abc/stim_word", word_at(0), 32'h61626300);
    build_model(3);
    check("abc/model_nblk", 32'(exp_nblk), 32'd1);
    check("abc/model_block", exp_blocks[0], {32'h61626380, {14{32'h0}}, 32'h00000018});
    run_msg("abc", 3, 2, 1'b0, 1);
    junk = 8'hA5;

    // Empty message
    msg_q.delete();
    build_model(0);
    check("len0/model_block", exp_blocks[0], {32'h80000000, {15{32'h0}}});
    run_msg("len0", 0, 1, 1'b0, 1);

    // Length field spills into an extra block
    make_msg(56, 1, 0);
    build_model(56);
    check("len56/model_nblk", 32'(exp_nblk), 32'd2);
    check("len56/model_b0_tail", exp_blocks[0][63:0], {32'h80000000, 32'h0});
    check("len56/model_b1", exp_blocks[1], {{15{32'h0}}, 32'h000001C0});
    run_msg("len56", 56, 3, 1'b0, 2);

    // Exact block: terminator at word0 of the next block; long HOLD stall
    make_msg(64, 16, 3);
    build_model(64);
    check("len64/model_b1", exp_blocks[1], {32'h80000000, {14{32'h0}}, 32'h00000200});
    run_msg("len64_hold", 64, 20, 1'b1, 2);

    // Partial final word in the 56..63 band, and a multi-block partial case
    make_msg(61, 32, 5);
    run_msg("len61", 61, 0, 1'b0, 2);
    make_msg(119, 51, 7);
    run_msg("len119", 119, 1, 1'b1, 2);

    // Reset after 7 words of a 100-byte message
    make_msg(100, 9, 11);
    @(negedge iClk);
    iStart = 1'b1; iMsgLen = 32'd100;
    @(negedge iClk);
    iStart = 1'b0;
    check("rst_mid/nblk", oNumberBlock, 32'd2);
    for (int i = 0; i < 7; i++) begin
      iWordValid = 1'b1;
      iWord = word_at(i);
      check("rst_mid/ready", oWordReady, 1'b1);
      @(negedge iClk);
    end
    iWordValid = 1'b0;
    iReset = 1'b1;
    @(negedge iClk);
    check_cleared("rst_mid");
    iReset = 1'b0;
    junk = 8'h00;
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_msg("abc_after_rst", 3, 0, 1'b0, 1);
    junk = 8'hA5;

    // Reset and start together: reset wins
    @(negedge iClk);
    iReset = 1'b1; iStart = 1'b1; iMsgLen = 32'd3;
    @(negedge iClk);
    iReset = 1'b0; iStart = 1'b0;
    check_cleared("rst_vs_start");

    // Soft clear via iEnable low mid-message
    @(negedge iClk);
    iStart = 1'b1; iMsgLen = 32'd3;
    @(negedge iClk);
    iStart = 1'b0;
    check("soft_clr/busy_before", oBusy, 1'b1);
    iEnable = 1'b0;
    @(negedge iClk);
    iEnable = 1'b1;
    check_cleared("soft_clr");
    repeat (2) @(negedge iClk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
